duck_sprite_fetch: RTL

//  Per-pixel sprite fetch/animation stage upstream of the sprite frame RAM (20x20 frames, palette idx).

---
 rtl/duck_sprite_fetch.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/duck_sprite_fetch.sv
// Sprite fetch stage: maps the scan position to a frame-RAM address, sequences the duck
// animation, and re-aligns the RAM read data with a delayed in-box flag for the colour mapper.
module duck_sprite_fetch #(
    parameter int SPR_W      = 20,
    parameter int SPR_H      = 20,
    parameter int FLY_FRAMES = 3,
    parameter int ANIM_DIV   = 8,
    parameter int SHOT_HOLD  = 30,
    parameter int ADDR_W     = 19,
    parameter int IDX_W      = 5,
    parameter int TRANSP_IDX = 0
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_start,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        spr_x,
    input  logic [9:0]        spr_y,
    input  logic              shot,
    input  logic              ground_hit,
    input  logic              respawn,
    input  logic [IDX_W-1:0]  mem_data,
    output logic [ADDR_W-1:0] read_address,
    output logic [IDX_W-1:0]  pix_idx,
    output logic              pix_opaque,
    output logic [1:0]        anim_state,
    output logic              shot_done
);

    localparam int STAGES = 2;
    localparam int SLOT_W = $clog2(FLY_FRAMES + 2);
    localparam int FRM_W  = (FLY_FRAMES > 1) ? $clog2(FLY_FRAMES) : 1;
    localparam int DIV_W  = (ANIM_DIV > 1)   ? $clog2(ANIM_DIV)   : 1;
    localparam int HOLD_W = (SHOT_HOLD > 1)  ? $clog2(SHOT_HOLD)  : 1;

    localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(FLY_FRAMES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(ANIM_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SHOT_HOLD - 1);
    localparam logic [ADDR_W-1:0] FRAME_SZ  = ADDR_W'(SPR_W * SPR_H);
    localparam logic [ADDR_W-1:0] ROW_SZ    = ADDR_W'(SPR_W);
    localparam logic [IDX_W-1:0]  TRANSP    = IDX_W'(TRANSP_IDX);

    typedef enum logic [1:0] {
        ST_FLY    = 2'd0,
        ST_SHOT   = 2'd1,
        ST_FALL   = 2'd2,
        ST_HIDDEN = 2'd3
    } state_t;

    state_t              state;
    logic [FRM_W-1:0]    fly_frame;
    logic [DIV_W-1:0]    div_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                shot_pend;
    logic [9:0]          ox, oy;
    logic [STAGES-1:0]   vld_pipe;

    logic [10:0]         dx, dy;
    logic                in_box;
    logic [SLOT_W-1:0]   slot;
    logic [ADDR_W-1:0]   base, addr_nxt;

    assign anim_state = state;

    // Origin only moves at vertical blank so a sprite never tears mid-frame.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ox <= '0;
            oy <= '0;
        end else if (frame_start) begin
            ox <= spr_x;
            oy <= spr_y;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_FLY;
            fly_frame <= '0;
            div_cnt   <= '0;
            hold_cnt  <= '0;
            shot_pend <= 1'b0;
            shot_done <= 1'b0;
        end else begin
            shot_done <= 1'b0;
            case (state)
                ST_FLY: begin
                    if (frame_start) begin
                        // A pending or same-cycle hit beats the wing-flap step.
                        if (shot_pend || shot) begin
                            state     <= ST_SHOT;
                            hold_cnt  <= '0;
                            shot_pend <= 1'b0;
                        end else if (div_cnt == DIV_LAST) begin
                            div_cnt   <= '0;
                            fly_frame <= (fly_frame == FRM_LAST) ? '0 : fly_frame + 1'b1;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end else if (shot) begin
                        shot_pend <= 1'b1;
                    end
                end
                ST_SHOT: begin
                    if (frame_start) begin
                        if (hold_cnt == HOLD_LAST) state <= ST_FALL;
                        else                       hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_FALL: begin
                    if (frame_start && ground_hit) begin
                        state     <= ST_HIDDEN;
                        shot_done <= 1'b1;
                    end
                end
                ST_HIDDEN: begin
                    if (respawn) begin
                        state     <= ST_FLY;
                        fly_frame <= '0;
                        div_cnt   <= '0;
                    end
                end
                default: state <= ST_FLY;
            endcase
        end
    end

    // 11-bit unsigned difference: left/above the origin wraps large and falls out of the box.
    always_comb begin
        dx     = {1'b0, DrawX} - {1'b0, ox};
        dy     = {1'b0, DrawY} - {1'b0, oy};
        in_box = (state != ST_HIDDEN) && (dx < 11'(SPR_W)) && (dy < 11'(SPR_H));
        case (state)
            ST_FLY:  slot = SLOT_W'(fly_frame);
            ST_SHOT: slot = SLOT_W'(FLY_FRAMES);
            ST_FALL: slot = SLOT_W'(FLY_FRAMES + 1);
            default: slot = '0;
        endcase
        base     = ADDR_W'(slot) * FRAME_SZ;
        addr_nxt = base;
        if (in_box) addr_nxt = base + ADDR_W'(dy) * ROW_SZ + ADDR_W'(dx);
    end

    // in_box rides alongside the address and the RAM's registered read.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            read_address <= '0;
            vld_pipe     <= '0;
            pix_idx      <= '0;
            pix_opaque   <= 1'b0;
        end else begin
            read_address <= addr_nxt;
            vld_pipe     <= {vld_pipe[STAGES-2:0], in_box};
            pix_idx      <= mem_data;
            pix_opaque   <= vld_pipe[STAGES-1] && (mem_data != TRANSP);
        end
    end

endmodule
